// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state codes, ACK/NACK bus levels, byte width.
// Latency: none (constants only).
// Backpressure: not applicable.
package i2c_pkg;
   localparam int BYTE_W = 8;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_ADDR      = 4'd1;
   localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
   localparam logic [3:0] ST_PTR       = 4'd3;
   localparam logic [3:0] ST_PTR_ACK   = 4'd4;
   localparam logic [3:0] ST_WDATA     = 4'd5;
   localparam logic [3:0] ST_WDATA_ACK = 4'd6;
   localparam logic [3:0] ST_RDATA     = 4'd7;
   localparam logic [3:0] ST_RDATA_ACK = 4'd8;
endpackage

// File: rtl/i2c_slave_if.sv
// Pad and register-port signals of the I2C target, bundled for one port.
// Latency: none (wires only).
// Backpressure: none; the register side must answer reg_re within 2 clk.
interface i2c_slave_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_out;
   logic       tristate;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       busy;

   modport slave (
      input  scl_in, sda_in, reg_rdata,
      output sda_out, tristate, reg_addr, reg_wdata, reg_we, reg_re, busy
   );

   modport master (
      output scl_in, sda_in, reg_rdata,
      input  sda_out, tristate, reg_addr, reg_wdata, reg_we, reg_re, busy
   );
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA and derives SCL edges plus START/STOP conditions.
// Latency: SYNC_STAGES clk from pad to sda_s; event pulses one clk wide.
// Backpressure: none; the pad lines are free-running.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);
   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_d;
   logic                   sda_d;
   logic                   scl_s;

   // Shift pads through the synchronisers; idle bus level is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_d    <= scl_sync[SYNC_STAGES-1];
         sda_d    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   // SDA may only move under SCL high for a bus condition, so require SCL high on both samples.
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, register pointer, byte writes/reads over a register port.
// Latency: SDA reacts 1 clk after the synchronised SCL fall; reg_we/reg_re are 1-clk strobes.
// Backpressure: none (no clock stretching); reg_rdata must be valid 2 clk after reg_re.
// Build option: define I2C_SLAVE_AUTOINC_EN to advance reg_addr after each byte.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input logic        clk,
   input logic        rst_n,
   i2c_slave_if.slave bus
);
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic       sda_s;
   logic [3:0] state;
   logic [2:0] bit_cnt;
   logic       byte_full;   // 8 bits sampled, act on the next SCL fall
   logic [7:0] shreg;
   logic       rw;
   logic       mack;        // master ACKed the last read byte
   logic       drive;       // 1 = pull SDA low

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_in    (bus.scl_in),
      .sda_in    (bus.sda_in),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   assign bus.tristate = ~drive;
   assign bus.sda_out  = ~drive;

   // Protocol FSM: bus conditions first, then sampling on SCL rise, then SDA updates on SCL fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         bit_cnt       <= 3'd0;
         byte_full     <= 1'b0;
         shreg         <= 8'h00;
         rw            <= 1'b0;
         mack          <= 1'b0;
         drive         <= 1'b0;
         bus.reg_addr  <= 8'h00;
         bus.reg_wdata <= 8'h00;
         bus.reg_we    <= 1'b0;
         bus.reg_re    <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         bus.reg_we <= 1'b0;
         bus.reg_re <= 1'b0;
`ifdef I2C_SLAVE_AUTOINC_EN
         if (bus.reg_we) bus.reg_addr <= bus.reg_addr + 8'd1;
`endif
         if (start_det) begin
            bus.busy  <= 1'b1;
            state     <= ST_ADDR;
            bit_cnt   <= 3'd0;
            byte_full <= 1'b0;
            drive     <= 1'b0;
         end else if (stop_det) begin
            bus.busy  <= 1'b0;
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            byte_full <= 1'b0;
            drive     <= 1'b0;
         end else if (scl_rise) begin
            case (state)
               ST_ADDR, ST_PTR, ST_WDATA: begin
                  shreg   <= {shreg[6:0], sda_s};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) byte_full <= 1'b1;
               end
               ST_RDATA: begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) byte_full <= 1'b1;
               end
               ST_ADDR_ACK: if (rw) bus.reg_re <= 1'b1;
               ST_RDATA_ACK: begin
                  mack <= (sda_s == ACK);
                  if (sda_s == ACK) begin
                     bus.reg_re <= 1'b1;
`ifdef I2C_SLAVE_AUTOINC_EN
                     bus.reg_addr <= bus.reg_addr + 8'd1;
`endif
                  end
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            case (state)
               ST_ADDR: if (byte_full) begin
                  byte_full <= 1'b0;
                  if (shreg[7:1] == SLAVE_ADDR) begin
                     state <= ST_ADDR_ACK;
                     drive <= 1'b1;
                     rw    <= shreg[0];
                  end else begin
                     state <= ST_IDLE;
                  end
               end
               ST_ADDR_ACK: begin
                  bit_cnt <= 3'd0;
                  if (rw) begin
                     state <= ST_RDATA;
                     shreg <= bus.reg_rdata;
                     drive <= ~bus.reg_rdata[7];
                  end else begin
                     state <= ST_PTR;
                     drive <= 1'b0;
                  end
               end
               ST_PTR: if (byte_full) begin
                  byte_full    <= 1'b0;
                  bus.reg_addr <= shreg;
                  drive        <= 1'b1;
                  state        <= ST_PTR_ACK;
               end
               ST_WDATA: if (byte_full) begin
                  byte_full     <= 1'b0;
                  bus.reg_wdata <= shreg;
                  bus.reg_we    <= 1'b1;
                  drive         <= 1'b1;
                  state         <= ST_WDATA_ACK;
               end
               ST_PTR_ACK, ST_WDATA_ACK: begin
                  bit_cnt <= 3'd0;
                  drive   <= 1'b0;
                  state   <= ST_WDATA;
               end
               ST_RDATA: begin
                  if (byte_full) begin
                     byte_full <= 1'b0;
                     drive     <= 1'b0;
                     state     <= ST_RDATA_ACK;
                  end else begin
                     shreg <= {shreg[6:0], 1'b0};
                     drive <= ~shreg[6];
                  end
               end
               ST_RDATA_ACK: begin
                  bit_cnt <= 3'd0;
                  if (mack) begin
                     state <= ST_RDATA;
                     shreg <= bus.reg_rdata;
                     drive <= ~bus.reg_rdata[7];
                  end else begin
                     state <= ST_IDLE;
                     drive <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, register-bank model and write/read scoreboard.
// Latency: master SCL half period is HP clk.
// Backpressure: none; the register model answers reads combinationally.
module tb_i2c_slave;
   import i2c_pkg::*;

   localparam int HP = 8;

   logic clk;
   logic rst_n;
   logic m_sda;
   logic [7:0] mem [256];

   logic [15:0] exp_wr[$];
   logic [7:0]  exp_rd[$];
   int n_checks = 0;
   int n_fail   = 0;
   int re_cnt   = 0;

   i2c_slave_if bus();

   i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Open-drain SDA: master and target both pull low.
   assign bus.sda_in    = m_sda & (bus.tristate | bus.sda_out);
   assign bus.reg_rdata = mem[bus.reg_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Register-port monitor: every write strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.reg_re) re_cnt++;
         if (bus.reg_we) begin
            if (exp_wr.size() == 0) check("we_unexpected", 32'd1, 32'd0);
            else check("wr_strobe", {16'h0, bus.reg_addr, bus.reg_wdata}, {16'h0, exp_wr.pop_front()});
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      wait_clk(2);
      m_sda = 1'b1;      wait_clk(HP);
      bus.scl_in = 1'b1; wait_clk(HP);
      m_sda = 1'b0;      wait_clk(HP);
      bus.scl_in = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(2);
      m_sda = 1'b0;      wait_clk(HP);
      bus.scl_in = 1'b1; wait_clk(HP);
      m_sda = 1'b1;      wait_clk(HP);
   endtask

   task automatic send_bit(input logic b, output logic s);
      wait_clk(2);
      m_sda = b;         wait_clk(HP - 2);
      bus.scl_in = 1'b1; wait_clk(HP / 2);
      s = bus.sda_in;    wait_clk(HP / 2);
      bus.scl_in = 1'b0;
   endtask

   task automatic xfer_byte(input logic [7:0] tx, input logic mbit,
                            output logic [7:0] rx, output logic ackb);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         send_bit(tx[i], b);
         rx[i] = b;
      end
      send_bit(mbit, ackb);
   endtask

   initial begin
      logic [7:0] rx;
      logic       ab;
      logic       b;
      logic [7:0] tx;
      int         r0;
      int         n;

      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[8'h07] = 8'h3C;
      mem[8'h20] = 8'hC5;
      mem[8'h21] = 8'h9A;

      rst_n = 1'b0; bus.scl_in = 1'b1; m_sda = 1'b1;
      wait_clk(5);
      check("rst_tristate", bus.tristate, 1);
      check("rst_sda_out", bus.sda_out, 1);
      check("rst_regs", {bus.reg_addr, bus.reg_wdata}, 0);
      check("rst_strobes", {bus.reg_we, bus.reg_re, bus.busy}, 0);
      rst_n = 1'b1;
      wait_clk(5);

      // Single write
      i2c_start();
      xfer_byte(8'hA0, NACK, rx, ab); check("wr_addr_ack", ab, ACK);
      check("busy_after_start", bus.busy, 1);
      xfer_byte(8'h12, NACK, rx, ab); check("wr_ptr_ack", ab, ACK);
      exp_wr.push_back({8'h12, 8'h5A});
      xfer_byte(8'h5A, NACK, rx, ab); check("wr_data_ack", ab, ACK);
      i2c_stop();
`ifdef I2C_SLAVE_AUTOINC_EN
      check("wr_ptr_final", bus.reg_addr, 8'h13);
`else
      check("wr_ptr_final", bus.reg_addr, 8'h12);
`endif
      check("wr_wdata", bus.reg_wdata, 8'h5A);
      check("busy_after_stop", bus.busy, 0);

      // Single read with repeated start and NACK
      r0 = re_cnt;
      i2c_start();
      xfer_byte(8'hA0, NACK, rx, ab); check("rd_addrw_ack", ab, ACK);
      xfer_byte(8'h07, NACK, rx, ab); check("rd_ptr_ack", ab, ACK);
      i2c_start();
      xfer_byte(8'hA1, NACK, rx, ab); check("rd_addrr_ack", ab, ACK);
      exp_rd.push_back(mem[8'h07]);
      xfer_byte(8'hFF, NACK, rx, ab); check("rd_byte", rx, exp_rd.pop_front());
      check("rd_released", bus.tristate, 1);
      i2c_stop();
      check("rd_re_count", re_cnt - r0, 1);

      // Two-byte read: master ACKs the first, NACKs the second
      r0 = re_cnt;
      i2c_start();
      xfer_byte(8'hA0, NACK, rx, ab);
      xfer_byte(8'h20, NACK, rx, ab);
      i2c_start();
      xfer_byte(8'hA1, NACK, rx, ab); check("rd2_addr_ack", ab, ACK);
      exp_rd.push_back(mem[8'h20]);
`ifdef I2C_SLAVE_AUTOINC_EN
      exp_rd.push_back(mem[8'h21]);
`else
      exp_rd.push_back(mem[8'h20]);
`endif
      xfer_byte(8'hFF, ACK, rx, ab);  check("rd2_byte0", rx, exp_rd.pop_front());
      xfer_byte(8'hFF, NACK, rx, ab); check("rd2_byte1", rx, exp_rd.pop_front());
      i2c_stop();
      check("rd2_re_count", re_cnt - r0, 2);

      // Address mismatch: no ACK, no strobes, busy until STOP
      r0 = re_cnt;
      i2c_start();
      xfer_byte(8'hA4, NACK, rx, ab); check("mm_addr_nack", ab, NACK);
      xfer_byte(8'h00, NACK, rx, ab); check("mm_ignored", ab, NACK);
      check("mm_busy", bus.busy, 1);
      i2c_stop();
      check("mm_busy_clear", bus.busy, 0);
      check("mm_no_re", re_cnt - r0, 0);

      // Burst write across the pointer wrap
      i2c_start();
      xfer_byte(8'hA0, NACK, rx, ab);
      xfer_byte(8'hFE, NACK, rx, ab);
`ifdef I2C_SLAVE_AUTOINC_EN
      exp_wr.push_back({8'hFE, 8'h11});
      exp_wr.push_back({8'hFF, 8'h22});
      exp_wr.push_back({8'h00, 8'h33});
`else
      exp_wr.push_back({8'hFE, 8'h11});
      exp_wr.push_back({8'hFE, 8'h22});
      exp_wr.push_back({8'hFE, 8'h33});
`endif
      xfer_byte(8'h11, NACK, rx, ab); check("burst_ack0", ab, ACK);
      xfer_byte(8'h22, NACK, rx, ab); check("burst_ack1", ab, ACK);
      xfer_byte(8'h33, NACK, rx, ab); check("burst_ack2", ab, ACK);
      i2c_stop();
      check("burst_all_written", exp_wr.size(), 0);

      // STOP in the middle of a data byte
      i2c_start();
      xfer_byte(8'hA0, NACK, rx, ab);
      xfer_byte(8'h10, NACK, rx, ab);
      tx = 8'hF0;
      for (int i = 7; i >= 4; i--) send_bit(tx[i], b);
      i2c_stop();
      wait_clk(4);
      check("abort_tristate", bus.tristate, 1);
      check("abort_busy", bus.busy, 0);
      check("abort_ptr", bus.reg_addr, 8'h10);

      // Asynchronous reset while the target drives ACK
      i2c_start();
      tx = 8'hA0;
      for (int i = 7; i >= 0; i--) send_bit(tx[i], b);
      m_sda = 1'b1;
      n = 0;
      while (bus.tristate && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rstack_driving", bus.tristate, 0);
      rst_n = 1'b0;
      #1;
      check("rstack_tristate", bus.tristate, 1);
      check("rstack_sda_out", bus.sda_out, 1);
      check("rstack_regs", {bus.reg_addr, bus.reg_wdata}, 0);
      check("rstack_strobes", {bus.reg_we, bus.reg_re, bus.busy}, 0);
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(HP);
      bus.scl_in = 1'b1;
      wait_clk(HP);
      check("rstack_idle", {bus.tristate, bus.busy}, 2'b10);
      check("no_pending_writes", exp_wr.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
